// File: rtl/irq_pending.sv
// Machine interrupt-pending vector: synchronizes PLIC lines, registers CLINT lines,
// compares stimecmp for Sstc and holds the software-writable pending bits.
module irq_pending #(
    parameter int unsigned XLEN           = 64,
    parameter bit          S_SUPPORTED    = 1'b1,
    parameter bit          SSTC_SUPPORTED = 1'b1,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MExtInt,
    input  logic            SExtInt,
    input  logic            MTimerInt,
    input  logic            MSwInt,
    input  logic [63:0]     MTIME,
    input  logic [63:0]     STIMECMP_REGW,
    input  logic            STCE,
    input  logic [11:0]     MIDELEG_REGW,
    input  logic            CSRMWriteM,
    input  logic            CSRSWriteM,
    input  logic [11:0]     CSRAdrM,
    input  logic [XLEN-1:0] CSRWriteValM,
    output logic [11:0]     MIP_REGW,
    output logic [11:0]     MIP_SW
);

    localparam logic [11:0] MipAdr = 12'h344;
    localparam logic [11:0] SipAdr = 12'h144;

    logic [SYNC_STAGES-1:0] mExtSync, sExtSync;
    logic                   mTip, mSip, stipCmp;
    logic                   swSsip, swSeip, swStip;
    logic                   stipHw, stip, mipWrite, sipWrite;
    logic [11:0]            wval;
    logic                   unusedBits;

    always_comb begin
        wval     = CSRWriteValM[11:0];
        stipHw   = SSTC_SUPPORTED && STCE;
        stip     = stipHw ? stipCmp : swStip;
        mipWrite = CSRMWriteM && (CSRAdrM == MipAdr);
        sipWrite = CSRSWriteM && (CSRAdrM == SipAdr);
    end

    // Only the low pending-bit field and MIDELEG[1] are consumed.
    assign unusedBits = ^{CSRWriteValM, MIDELEG_REGW};

    always_ff @(posedge clk) begin
        if (reset) begin
            mExtSync <= '0;
            sExtSync <= '0;
            mTip     <= 1'b0;
            mSip     <= 1'b0;
            stipCmp  <= 1'b0;
            swSsip   <= 1'b0;
            swSeip   <= 1'b0;
            swStip   <= 1'b0;
        end else begin
            mExtSync <= {mExtSync[SYNC_STAGES-2:0], MExtInt};
            sExtSync <= {sExtSync[SYNC_STAGES-2:0], SExtInt};
            mTip     <= MTimerInt;
            mSip     <= MSwInt;
            stipCmp  <= SSTC_SUPPORTED && (MTIME >= STIMECMP_REGW);
            if (S_SUPPORTED) begin
                if (mipWrite) begin
                    swSsip <= wval[1];
                    swSeip <= wval[9];
                    // sw_stip keeps its old value while the comparator owns STIP.
                    if (!stipHw) swStip <= wval[5];
                end else if (sipWrite && MIDELEG_REGW[1]) begin
                    swSsip <= wval[1];
                end
            end
        end
    end

    always_comb begin
        MIP_REGW     = '0;
        MIP_REGW[11] = mExtSync[SYNC_STAGES-1];
        MIP_REGW[7]  = mTip;
        MIP_REGW[3]  = mSip;
        if (S_SUPPORTED) begin
            MIP_REGW[9] = swSeip | sExtSync[SYNC_STAGES-1];
            MIP_REGW[5] = stip;
            MIP_REGW[1] = swSsip;
        end
        // Software reads SEIP without the external line folded in.
        MIP_SW    = MIP_REGW;
        MIP_SW[9] = S_SUPPORTED && swSeip;
    end

endmodule

// File: tb/tb_irq_pending.sv
// Scoreboard bench for irq_pending: default build plus an S_SUPPORTED=0, XLEN=32 build.
module tb_irq_pending;

    logic        clk = 1'b0;
    logic        reset;
    logic        MExtInt, SExtInt, MTimerInt, MSwInt, STCE;
    logic [63:0] MTIME, STIMECMP_REGW, valM;
    logic [11:0] MIDELEG_REGW, CSRAdrM;
    logic        CSRMWriteM, CSRSWriteM;
    logic [11:0] mipRegw, mipSw, mipRegw0, mipSw0;

    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        int          atCyc;
        bit          which;
        logic [11:0] mask;
        logic [11:0] expRegw;
        logic [11:0] expSw;
        string       name;
    } exp_t;

    exp_t scoreQ[$];

    irq_pending dut (
        .clk(clk), .reset(reset), .MExtInt(MExtInt), .SExtInt(SExtInt),
        .MTimerInt(MTimerInt), .MSwInt(MSwInt), .MTIME(MTIME), .STIMECMP_REGW(STIMECMP_REGW),
        .STCE(STCE), .MIDELEG_REGW(MIDELEG_REGW), .CSRMWriteM(CSRMWriteM),
        .CSRSWriteM(CSRSWriteM), .CSRAdrM(CSRAdrM), .CSRWriteValM(valM),
        .MIP_REGW(mipRegw), .MIP_SW(mipSw)
    );

    irq_pending #(.XLEN(32), .S_SUPPORTED(1'b0)) dut0 (
        .clk(clk), .reset(reset), .MExtInt(MExtInt), .SExtInt(SExtInt),
        .MTimerInt(MTimerInt), .MSwInt(MSwInt), .MTIME(MTIME), .STIMECMP_REGW(STIMECMP_REGW),
        .STCE(STCE), .MIDELEG_REGW(MIDELEG_REGW), .CSRMWriteM(CSRMWriteM),
        .CSRSWriteM(CSRSWriteM), .CSRAdrM(CSRAdrM), .CSRWriteValM(valM[31:0]),
        .MIP_REGW(mipRegw0), .MIP_SW(mipSw0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due on this cycle.
    always @(negedge clk) begin
        for (int i = scoreQ.size() - 1; i >= 0; i--) begin
            if (scoreQ[i].atCyc == cyc) begin
                logic [11:0] gr, gs;
                gr = scoreQ[i].which ? mipRegw0 : mipRegw;
                gs = scoreQ[i].which ? mipSw0 : mipSw;
                checks++;
                if ((((gr ^ scoreQ[i].expRegw) | (gs ^ scoreQ[i].expSw)) & scoreQ[i].mask) != 0)
                begin
                    errors++;
                    $display("FAIL %s: MIP_REGW=%h MIP_SW=%h, required %h %h (mask %h)",
                             scoreQ[i].name, gr, gs, scoreQ[i].expRegw, scoreQ[i].expSw,
                             scoreQ[i].mask);
                end
                scoreQ.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int d, input bit which, input logic [11:0] mask,
                       input logic [11:0] er, input logic [11:0] es, input string nm);
        exp_t e;
        e.atCyc = cyc + d; e.which = which; e.mask = mask;
        e.expRegw = er; e.expSw = es; e.name = nm;
        scoreQ.push_back(e);
    endtask

    task automatic mipWr(input logic [11:0] v);
        CSRMWriteM = 1'b1; CSRSWriteM = 1'b0; CSRAdrM = 12'h344; valM = {52'h0, v};
    endtask

    task automatic noWr();
        CSRMWriteM = 1'b0; CSRSWriteM = 1'b0; CSRAdrM = 12'h000; valM = '0;
    endtask

    initial begin
        reset = 1'b1; MExtInt = 0; SExtInt = 0; MTimerInt = 0; MSwInt = 0; STCE = 0;
        MTIME = '0; STIMECMP_REGW = '0; MIDELEG_REGW = '0; noWr();
        tick(); tick();
        reset = 1'b0;
        chk(0, 0, 12'hFFF, 12'h000, 12'h000, "resetDut");
        chk(0, 1, 12'hFFF, 12'h000, 12'h000, "resetDut0");
        tick(); tick();

        // MEIP through the two-flop synchronizer
        MExtInt = 1'b1;
        chk(1, 0, 12'hFFF, 12'h000, 12'h000, "meipNotYet");
        chk(2, 0, 12'hFFF, 12'h800, 12'h800, "meipRise");
        repeat (5) tick();
        MExtInt = 1'b0;
        chk(1, 0, 12'h800, 12'h800, 12'h800, "meipHeld");
        chk(2, 0, 12'hFFF, 12'h000, 12'h000, "meipFall");
        repeat (3) tick();

        // mip write, then clear with SExtInt held
        mipWr(12'h222);
        chk(1, 0, 12'hFFF, 12'h222, 12'h222, "mipWrite222");
        chk(1, 1, 12'hFFF, 12'h000, 12'h000, "s0MipWrite");
        tick();
        mipWr(12'h000); SExtInt = 1'b1;
        chk(1, 0, 12'hFFF, 12'h000, 12'h000, "mipClear");
        chk(2, 0, 12'hFFF, 12'h200, 12'h000, "seipExtOnly");
        chk(2, 1, 12'hFFF, 12'h000, 12'h000, "s0SeipTied");
        tick();
        noWr();
        tick();
        SExtInt = 1'b0;
        repeat (3) tick();

        // Sstc comparator
        STCE = 1'b1; MTIME = 64'hFF; STIMECMP_REGW = 64'h100;
        chk(1, 0, 12'h020, 12'h000, 12'h000, "stipBelow");
        tick();
        MTIME = 64'h100;
        chk(1, 0, 12'h020, 12'h020, 12'h020, "stipEqual");
        chk(1, 1, 12'h020, 12'h000, 12'h000, "s0StipTied");
        tick();
        mipWr(12'h000);
        chk(1, 0, 12'h020, 12'h020, 12'h020, "stipReadOnly");
        tick();
        noWr(); MTIME = 64'h7FFF_FFFF_FFFF_FFFF; STIMECMP_REGW = 64'h8000_0000_0000_0000;
        chk(1, 0, 12'h020, 12'h000, 12'h000, "stipUnsigned");
        tick();
        mipWr(12'h020);
        tick();
        noWr(); STCE = 1'b0;
        chk(0, 0, 12'hFFF, 12'h000, 12'h000, "swStipNotWritten");
        tick();

        // sip writes honour MIDELEG[1] only for SSIP
        CSRSWriteM = 1'b1; CSRAdrM = 12'h144; valM = 64'h2;
        chk(1, 0, 12'h002, 12'h000, 12'h000, "sipNoDeleg");
        tick();
        MIDELEG_REGW = 12'h002;
        chk(1, 0, 12'h002, 12'h002, 12'h002, "sipDeleg");
        tick();
        valM = 64'h20;
        chk(1, 0, 12'h022, 12'h000, 12'h000, "sipStipIgnored");
        tick();
        CSRSWriteM = 1'b0; CSRMWriteM = 1'b1; CSRAdrM = 12'h345; valM = 64'h222;
        chk(1, 0, 12'hFFF, 12'h000, 12'h000, "otherAdr");
        tick();

        // Reset mid-operation
        mipWr(12'h002);
        tick();
        noWr(); MExtInt = 1'b1;
        chk(3, 0, 12'hFFF, 12'h802, 12'h802, "preReset");
        repeat (3) tick();
        reset = 1'b1;
        chk(1, 0, 12'hFFF, 12'h000, 12'h000, "resetClears");
        tick();
        reset = 1'b0;
        chk(1, 0, 12'hFFF, 12'h000, 12'h000, "postResetSync");
        chk(2, 0, 12'hFFF, 12'h800, 12'h800, "meipReturns");
        repeat (3) tick();
        MExtInt = 1'b0;
        repeat (3) tick();

        // CLINT lines, one cycle latency
        MTimerInt = 1'b1; MSwInt = 1'b1;
        chk(1, 0, 12'hFFF, 12'h088, 12'h088, "clintRise");
        chk(1, 1, 12'hFFF, 12'h088, 12'h088, "s0ClintRise");
        tick();
        MTimerInt = 1'b0; MSwInt = 1'b0;
        chk(1, 0, 12'h088, 12'h000, 12'h000, "clintFall");
        tick();

        // All-ones mip write
        mipWr(12'hFFF);
        chk(1, 0, 12'hFFF, 12'h222, 12'h222, "mipWriteFFF");
        chk(1, 1, 12'hFFF, 12'h000, 12'h000, "s0WriteFFF");
        tick();
        noWr();
        repeat (4) tick();

        if (scoreQ.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations unchecked, required 0", scoreQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
